// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris keyboard input path: lane indices and
// the per-lane auto-repeat state encoding.
package tetris_input_pkg;

  // Lane order of the move vector
  localparam int KEY_LEFT   = 0;
  localparam int KEY_RIGHT  = 1;
  localparam int KEY_ROTATE = 2;
  localparam int KEY_DOWN   = 3;

  // Per-lane auto-repeat state
  typedef enum logic [1:0] {
    LANE_IDLE   = 2'd0,
    LANE_DELAY  = 2'd1,
    LANE_REPEAT = 2'd2,
    LANE_LOCKED = 2'd3
  } lane_state_t;

  // True while a lane is counting towards its next pulse
  function automatic logic lane_busy(input lane_state_t s);
    return (s == LANE_DELAY) || (s == LANE_REPEAT);
  endfunction

endpackage

// File: rtl/key_repeat_lane.sv
// One auto-repeat lane: turns a held key level into an initial pulse, a
// delayed first repeat and periodic repeats. Holds the lane FSM, its counter
// and the previous key sample used for press detection.
module key_repeat_lane
  import tetris_input_pkg::*;
#(
  parameter int DELAY_CYCLES  = 8_333_333,
  parameter int REPEAT_CYCLES = 2_500_000,
  parameter int CNT_W         = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        held,
  input  logic        press,
  input  logic        force_lock,
  input  logic        repeat_en,
  output logic        prev,
  output logic        pulse,
  output lane_state_t state_next
);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  lane_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             pulse_next;

  // State, counter and pulse registers; prev resets high so a key held
  // through reset is not seen as a fresh press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= LANE_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      prev  <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pulse <= pulse_next;
      prev  <= held;
    end
  end

  // Next-state logic: disable and release take priority over everything,
  // then an arbitration lock, then the delay/repeat counting. The counter
  // stays cleared unless a state explicitly keeps counting.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    pulse_next = 1'b0;
    if (!enable || !held) begin
      state_next = LANE_IDLE;
    end else begin
      case (state)
        LANE_IDLE: begin
          if (press) begin
            pulse_next = 1'b1;
            state_next = force_lock ? LANE_LOCKED : LANE_DELAY;
          end
        end
        LANE_DELAY: begin
          if (force_lock) begin
            state_next = LANE_LOCKED;
          end else if (cnt == DELAY_LAST) begin
            pulse_next = repeat_en;
            state_next = repeat_en ? LANE_REPEAT : LANE_LOCKED;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        LANE_REPEAT: begin
          if (force_lock) begin
            state_next = LANE_LOCKED;
          end else if (cnt == REPEAT_LAST) begin
            pulse_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        LANE_LOCKED: begin
          state_next = LANE_LOCKED;
        end
        default: begin
          state_next = LANE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_autorepeat.sv
// Key auto-repeat for the game controller: one lane per key, with
// last-pressed-wins arbitration between left and right.
//
// Handshake note: there is no valid/ready pairing here; key_pulse is a
// single-cycle strobe that the consumer must take in the cycle it is high.
module key_autorepeat
  import tetris_input_pkg::*;
#(
  parameter int                N_KEYS        = 4,
  parameter int                DELAY_CYCLES  = 8_333_333,
  parameter int                REPEAT_CYCLES = 2_500_000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK   = 4'b1011,
  parameter int                CNT_W         = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [N_KEYS-1:0] key_held,
  output logic [N_KEYS-1:0] key_pulse,
  output logic              active
);

  logic [N_KEYS-1:0] prev;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] force_lock;
  logic [N_KEYS-1:0] pulse;
  lane_state_t       state_next [N_KEYS];
  logic              active_next;

  assign press     = key_held & ~prev;
  assign key_pulse = pulse;

  // A press on left locks a counting right lane and vice versa; the lane
  // ignores the lock unless it is counting or pressing in the same cycle.
  always_comb begin
    force_lock            = '0;
    force_lock[KEY_LEFT]  = press[KEY_RIGHT];
    force_lock[KEY_RIGHT] = press[KEY_LEFT];
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
    key_repeat_lane #(
      .DELAY_CYCLES  (DELAY_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .held       (key_held[i]),
      .press      (press[i]),
      .force_lock (force_lock[i]),
      .repeat_en  (REPEAT_MASK[i]),
      .prev       (prev[i]),
      .pulse      (pulse[i]),
      .state_next (state_next[i])
    );
  end

  // Any lane heading into DELAY or REPEAT makes the block active next cycle
  always_comb begin
    active_next = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (lane_busy(state_next[i])) active_next = 1'b1;
    end
  end

  // Registered activity flag, aligned with the lane state registers
  always_ff @(posedge clk) begin
    if (!reset_n) active <= 1'b0;
    else          active <= active_next;
  end

endmodule

// File: tb/tb_key_autorepeat.sv
// Directed bench for key_autorepeat with short delay/repeat constants.
// Expected pulses are queued as {edge, lane vector} when a scenario is set
// up; a negedge monitor pops and compares each pulse the DUT produces.
module tb_key_autorepeat;

  localparam int N_KEYS = 4;
  localparam int DELAY  = 10;
  localparam int REPEAT = 4;
  localparam int W      = 20;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [N_KEYS-1:0] key_held;
  logic [N_KEYS-1:0] key_pulse;
  logic              active;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int t0       = 0;

  logic [W-1:0] exp_q[$];

  key_autorepeat #(
    .N_KEYS        (N_KEYS),
    .DELAY_CYCLES  (DELAY),
    .REPEAT_CYCLES (REPEAT),
    .REPEAT_MASK   (4'b1011),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .key_held  (key_held),
    .key_pulse (key_pulse),
    .active    (active)
  );

  // Clock and edge counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scenario timing: inputs set in to_edge(r) are sampled at edge t0+r
  task automatic start_scn();
    t0 = edge_cnt;
  endtask

  task automatic to_edge(input int r);
    while (edge_cnt < t0 + r - 1) @(negedge clk);
  endtask

  task automatic expect_pulse(input int r, input logic [N_KEYS-1:0] lanes);
    int e;
    e = t0 + r;
    exp_q.push_back({16'(e), lanes});
  endtask

  task automatic check_drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Pulse monitor: every nonzero key_pulse must match the next queued entry
  always @(negedge clk) begin
    logic [W-1:0] obs;
    if (reset_n && key_pulse != '0) begin
      obs = {16'(edge_cnt), key_pulse};
      if (exp_q.size() == 0) check("pulse_unexpected", 32'(obs), 32'd0);
      else                   check("pulse", 32'(obs), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    key_held = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_pulse", 32'(key_pulse), 32'd0);
    check("reset_active", 32'(active), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Tap: left held for edges 5..7
    start_scn();
    to_edge(5);  key_held = 4'b0001; expect_pulse(5, 4'b0001);
    to_edge(6);  check("tap_active_on", 32'(active), 32'd1);
    to_edge(8);  check("tap_active_held", 32'(active), 32'd1); key_held = 4'b0000;
    to_edge(9);  check("tap_active_off", 32'(active), 32'd0);
    to_edge(20); check_drained("tap_missing");

    // Hold: down held edges 5..40
    start_scn();
    to_edge(5); key_held = 4'b1000;
    expect_pulse(5, 4'b1000);
    for (int k = 0; k < 7; k++) expect_pulse(15 + k * REPEAT, 4'b1000);
    to_edge(41); check("hold_active_on", 32'(active), 32'd1); key_held = 4'b0000;
    to_edge(42); check("hold_active_off", 32'(active), 32'd0);
    to_edge(50); check_drained("hold_missing");

    // Release on the same edge a repeat pulse is due: release wins
    start_scn();
    to_edge(5);  key_held = 4'b1000;
    expect_pulse(5, 4'b1000); expect_pulse(15, 4'b1000); expect_pulse(19, 4'b1000);
    to_edge(23); key_held = 4'b0000;
    to_edge(32); check_drained("release_wins_missing");

    // Rotate: no auto-repeat, locks at edge 15, re-press after release fires
    start_scn();
    to_edge(5);  key_held = 4'b0100; expect_pulse(5, 4'b0100);
    to_edge(15); check("rot_active_delay", 32'(active), 32'd1);
    to_edge(16); check("rot_active_locked", 32'(active), 32'd0);
    to_edge(35); key_held = 4'b0000;
    to_edge(40); key_held = 4'b0100; expect_pulse(40, 4'b0100);
    to_edge(42); key_held = 4'b0000;
    to_edge(50); check_drained("rot_missing");

    // Arbitration: right at 12 locks left; left re-press at 30 locks right
    start_scn();
    to_edge(5);  key_held = 4'b0001; expect_pulse(5, 4'b0001);
    to_edge(12); key_held = 4'b0011;
    expect_pulse(12, 4'b0010); expect_pulse(22, 4'b0010); expect_pulse(26, 4'b0010);
    to_edge(28); key_held = 4'b0010;
    to_edge(30); key_held = 4'b0011; expect_pulse(30, 4'b0001);
    to_edge(31); check("arb_active", 32'(active), 32'd1);
    to_edge(35); key_held = 4'b0000;
    to_edge(45); check_drained("arb_missing");

    // Both left and right pressed together: one pulse each, then locked
    start_scn();
    to_edge(5);  key_held = 4'b0011; expect_pulse(5, 4'b0011);
    to_edge(6);  check("both_active", 32'(active), 32'd0);
    to_edge(25); key_held = 4'b0000;
    to_edge(30); check_drained("both_missing");

    // Reset mid-DELAY with key still held: no pulse until re-pressed
    start_scn();
    to_edge(3);  key_held = 4'b1000; expect_pulse(3, 4'b1000);
    to_edge(8);  reset_n = 1'b0;
    to_edge(9);  check("rst_mid_pulse", 32'(key_pulse), 32'd0);
                 check("rst_mid_active", 32'(active), 32'd0);
    to_edge(10); reset_n = 1'b1;
    to_edge(11); check("rst_after_active", 32'(active), 32'd0);
    to_edge(20); key_held = 4'b0000;
    to_edge(22); key_held = 4'b1000; expect_pulse(22, 4'b1000);
    to_edge(24); key_held = 4'b0000;
    to_edge(30); check_drained("rst_missing");

    // Enable low while down held, then raised: no pulse until re-press
    start_scn();
    to_edge(3);  key_held = 4'b1000; expect_pulse(3, 4'b1000);
    to_edge(6);  enable = 1'b0;
    to_edge(7);  check("en_low_active", 32'(active), 32'd0);
    to_edge(12); enable = 1'b1;
    to_edge(25); key_held = 4'b0000;
    to_edge(27); key_held = 4'b1000; expect_pulse(27, 4'b1000);
    to_edge(28); check("en_repress_active", 32'(active), 32'd1);
    to_edge(29); key_held = 4'b0000;
    to_edge(35); check_drained("en_missing");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
